// File: rtl/dnlink_serializer_if.sv
// Handshake/bus bundle for the downlink serializer: holding-buffer write port,
// frame control strobes and the serial output status.
interface dnlink_if #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 2
);
    localparam int IDXW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int NBITS = 1 + NWORDS * WORD_W;
    localparam int CTRW  = $clog2(NBITS + 1);

    logic              wr_en;
    logic [IDXW-1:0]   wr_idx;
    logic [WORD_W-1:0] wr_data;
    logic              order_in;
    logic              dk_strt;
    logic              dk_bsnc;
    logic              clr_ovr;
    logic              dk_data;
    logic              busy;
    logic [CTRW-1:0]   bit_ctr;
    logic              downrupt;
    logic              stale;
    logic              overrun;

    modport master (
        output wr_en, wr_idx, wr_data, order_in, dk_strt, dk_bsnc, clr_ovr,
        input  dk_data, busy, bit_ctr, downrupt, stale, overrun
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, order_in, dk_strt, dk_bsnc, clr_ovr,
        output dk_data, busy, bit_ctr, downrupt, stale, overrun
    );
endinterface

// File: rtl/dnlink_serializer.sv
// Downlink telemetry serializer: captures the holding buffer into a shadow
// register on frame start and shifts it out one bit per bit-sync strobe.
module dnlink_serializer #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 2
) (
    input  logic     clk,
    input  logic     rst,
    dnlink_if.slave  bus
);
    localparam int IDXW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int NBITS = 1 + NWORDS * WORD_W;
    localparam int CTRW  = $clog2(NBITS + 1);
    localparam logic [CTRW-1:0] LAST_BIT = CTRW'(NBITS - 1);
    localparam logic [CTRW-1:0] CTR_ONE  = CTRW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WORD_W-1:0] buf_r [NWORDS];
    logic [NWORDS-1:0] fresh_r;
    logic [NWORDS-1:0] fresh_nxt_s;
    logic [NBITS-1:0]  shadow_r;
    logic [NBITS-1:0]  cap_s;
    logic [CTRW-1:0]   bit_ctr_r;
    logic              dk_data_r;
    logic              busy_r;
    logic              downrupt_r;
    logic              stale_r;
    logic              overrun_r;
    logic              start_s;
    logic              adv_s;
    logic              last_s;
    logic              wr_ok_s;

    // Decode frame events and the next FSM state.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        adv_s       = 1'b0;
        last_s      = 1'b0;
        wr_ok_s     = bus.wr_en && (32'(bus.wr_idx) < 32'(NWORDS));
        case (state_r)
            ST_IDLE, ST_DONE: begin
                start_s = bus.dk_strt;
                if (bus.dk_strt) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                adv_s  = bus.dk_bsnc;
                last_s = bus.dk_bsnc && (bit_ctr_r == LAST_BIT);
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Frame image: order bit first, then word0..wordN-1, each MSB first.
    always_comb begin
        cap_s            = '0;
        cap_s[NBITS-1]   = bus.order_in;
        for (int i = 0; i < NWORDS; i++) begin
            cap_s[NBITS-2-i*WORD_W -: WORD_W] = buf_r[i];
        end
    end

    // Fresh flags clear on capture; a same-cycle write still marks its word fresh.
    always_comb begin
        fresh_nxt_s = fresh_r;
        if (start_s) begin
            fresh_nxt_s = '0;
        end else begin
            fresh_nxt_s = fresh_r;
        end
        if (wr_ok_s) begin
            fresh_nxt_s[bus.wr_idx] = 1'b1;
        end else begin
            fresh_nxt_s[0] = fresh_nxt_s[0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding buffer and fresh flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                buf_r[i] <= '0;
            end
            fresh_r <= '0;
        end else begin
            if (wr_ok_s) begin
                buf_r[bus.wr_idx] <= bus.wr_data;
            end
            fresh_r <= fresh_nxt_s;
        end
    end

    // Shadow shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r   <= '0;
            dk_data_r  <= 1'b0;
            busy_r     <= 1'b0;
            bit_ctr_r  <= '0;
            downrupt_r <= 1'b0;
            stale_r    <= 1'b0;
        end else begin
            downrupt_r <= 1'b0;
            if (start_s) begin
                shadow_r  <= cap_s;
                dk_data_r <= bus.order_in;
                busy_r    <= 1'b1;
                bit_ctr_r <= '0;
                stale_r   <= ~(&fresh_r);
            end else if (last_s) begin
                dk_data_r  <= 1'b0;
                busy_r     <= 1'b0;
                bit_ctr_r  <= '0;
                downrupt_r <= 1'b1;
            end else if (adv_s) begin
                // shadow MSB is the bit on the line, so the next one sits just below it
                shadow_r  <= {shadow_r[NBITS-2:0], 1'b0};
                dk_data_r <= shadow_r[NBITS-2];
                bit_ctr_r <= bit_ctr_r + CTR_ONE;
            end
        end
    end

    // Sticky overrun: a start during SHIFT beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if ((state_r == ST_SHIFT) && bus.dk_strt) begin
            overrun_r <= 1'b1;
        end else if (bus.clr_ovr) begin
            overrun_r <= 1'b0;
        end
    end

    assign bus.dk_data  = dk_data_r;
    assign bus.busy     = busy_r;
    assign bus.bit_ctr  = bit_ctr_r;
    assign bus.downrupt = downrupt_r;
    assign bus.stale    = stale_r;
    assign bus.overrun  = overrun_r;
endmodule

// File: tb/tb_dnlink_serializer.sv
// Randomized scoreboard bench for dnlink_serializer: the driver predicts each
// frame from a word-level model, a negedge monitor checks what the DUT sends.
module tb_dnlink_serializer;
    localparam int WORD_W = 16;
    localparam int NWORDS = 2;
    localparam int NBITS  = 1 + NWORDS * WORD_W;

    typedef struct {
        logic [NBITS-1:0] bits;   // bits[i] is the i-th transmitted bit
        logic             stale;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dnlink_if #(.WORD_W(WORD_W), .NWORDS(NWORDS)) bus ();

    dnlink_serializer #(.WORD_W(WORD_W), .NWORDS(NWORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] mbuf [NWORDS];
    bit                mfresh [NWORDS];
    frame_t            q [$];
    int                exp_dr = 0;
    int                mon_dr = 0;
    bit                abort_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int w = 0; w < NWORDS; w++) begin
            mbuf[w]   = '0;
            mfresh[w] = 1'b0;
        end
    endtask

    task automatic m_write(input int idx, input logic [WORD_W-1:0] d);
        if (idx < NWORDS) begin
            mbuf[idx]   = d;
            mfresh[idx] = 1'b1;
        end
    endtask

    task automatic m_start(input bit order);
        frame_t f;
        bit all_fresh = 1'b1;
        f.bits    = '0;
        f.bits[0] = order;
        for (int w = 0; w < NWORDS; w++) begin
            for (int b = 0; b < WORD_W; b++) begin
                f.bits[1 + w*WORD_W + b] = mbuf[w][WORD_W-1-b];
            end
            all_fresh = all_fresh & mfresh[w];
            mfresh[w] = 1'b0;
        end
        f.stale = !all_fresh;
        q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.wr_en   = 1'b0;
        bus.dk_strt = 1'b0;
        bus.dk_bsnc = 1'b0;
        bus.clr_ovr = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [WORD_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx[0:0];
        bus.wr_data = d;
        m_write(idx, d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    // start a frame, optionally with a same-cycle write and a (to be ignored) bit-sync
    task automatic start(input bit order, input bit wr, input int idx, input logic [WORD_W-1:0] d);
        bus.order_in = order;
        bus.dk_strt  = 1'b1;
        bus.dk_bsnc  = ($urandom_range(0, 1) == 1);
        m_start(order);
        if (wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_idx  = idx[0:0];
            bus.wr_data = d;
            m_write(idx, d);
        end
        tick();
        clear_in();
    endtask

    task automatic bits(input int n, input int gmin, input int gmax, input bit rndwr);
        for (int i = 0; i < n; i++) begin
            int gap = $urandom_range(gmin, gmax);
            for (int g = 1; g < gap; g++) begin
                if (rndwr && $urandom_range(0, 2) == 0) begin
                    int idx = $urandom_range(0, NWORDS-1);
                    logic [WORD_W-1:0] d = WORD_W'($urandom);
                    bus.wr_en   = 1'b1;
                    bus.wr_idx  = idx[0:0];
                    bus.wr_data = d;
                    m_write(idx, d);
                end
                tick();
                bus.wr_en = 1'b0;
            end
            bus.dk_bsnc = 1'b1;
            tick();
            bus.dk_bsnc = 1'b0;
        end
    endtask

    // Monitor / scoreboard
    frame_t    cur;
    bit        have = 1'b0;
    int        idx = 0;
    logic      pbusy = 1'b0;
    logic      pdr = 1'b0;
    logic [5:0] pctr = '0;
    logic      last_stale = 1'b0;

    always @(negedge clk) begin
        if (pbusy && !bus.busy && !bus.downrupt) begin
            if (abort_pending) begin
                abort_pending = 1'b0;
                last_stale    = 1'b0;
            end else begin
                check("busy_drop_without_downrupt", 64'(bus.busy), 64'd1);
            end
            have = 1'b0;
        end
        if (!pbusy && bus.busy) begin
            if (q.size() == 0) begin
                check("unexpected_frame_start", 64'(bus.busy), 64'd0);
            end else begin
                cur        = q.pop_front();
                have       = 1'b1;
                idx        = 0;
                last_stale = cur.stale;
                check("start_bit_ctr", 64'(bus.bit_ctr), 64'd0);
                check("start_dk_data", 64'(bus.dk_data), 64'(cur.bits[0]));
                check("start_stale", 64'(bus.stale), 64'(cur.stale));
            end
        end else if (bus.busy && have) begin
            if (bus.bit_ctr != pctr) idx++;
            if (idx < NBITS) begin
                check("bit_ctr", 64'(bus.bit_ctr), 64'(idx));
                check("dk_data", 64'(bus.dk_data), 64'(cur.bits[idx]));
                check("stale_hold", 64'(bus.stale), 64'(cur.stale));
            end else begin
                check("bit_overflow", 64'(idx), 64'(NBITS-1));
            end
        end
        if (bus.downrupt) begin
            mon_dr++;
            check("downrupt_index", 64'(idx), 64'(NBITS-1));
            check("downrupt_busy", 64'(bus.busy), 64'd0);
            check("downrupt_dk_data", 64'(bus.dk_data), 64'd0);
            check("downrupt_bit_ctr", 64'(bus.bit_ctr), 64'd0);
            check("downrupt_width", 64'(pdr), 64'd0);
            have = 1'b0;
        end
        if (!bus.busy && !bus.downrupt) begin
            check("idle_dk_data", 64'(bus.dk_data), 64'd0);
            check("idle_bit_ctr", 64'(bus.bit_ctr), 64'd0);
            check("idle_stale", 64'(bus.stale), 64'(last_stale));
        end
        pbusy = bus.busy;
        pdr   = bus.downrupt;
        pctr  = bus.bit_ctr;
    end

    initial begin
        int d0;
        clear_in();
        bus.wr_idx   = '0;
        bus.wr_data  = '0;
        bus.order_in = 1'b0;
        m_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("rst_dk_data", 64'(bus.dk_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_bit_ctr", 64'(bus.bit_ctr), 64'd0);
        check("rst_downrupt", 64'(bus.downrupt), 64'd0);
        check("rst_stale", 64'(bus.stale), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);

        // Known words, fresh frame then a repeat without writes (stale)
        do_write(0, 16'hA5C3);
        do_write(1, 16'h0F0F);
        start(1'b1, 1'b0, 0, '0);
        bits(NBITS, 3, 3, 1'b0);
        exp_dr++;
        repeat (3) tick();
        start(1'b1, 1'b0, 0, '0);
        bits(NBITS, 3, 3, 1'b0);
        exp_dr++;
        repeat (2) tick();

        // Overrun: start during SHIFT is ignored for data but flagged
        start(1'b0, 1'b0, 0, '0);
        bits(5, 1, 3, 1'b0);
        bus.dk_strt = 1'b1;
        tick();
        bus.dk_strt = 1'b0;
        @(negedge clk);
        check("overrun_set", 64'(bus.overrun), 64'd1);
        bits(5, 1, 3, 1'b0);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        @(negedge clk);
        check("overrun_clear", 64'(bus.overrun), 64'd0);
        bus.dk_strt = 1'b1;
        bus.clr_ovr = 1'b1;
        tick();
        clear_in();
        @(negedge clk);
        check("overrun_set_wins", 64'(bus.overrun), 64'd1);
        bus.clr_ovr = 1'b1;
        tick();
        bus.clr_ovr = 1'b0;
        @(negedge clk);
        check("overrun_clear2", 64'(bus.overrun), 64'd0);
        bits(NBITS - 10, 1, 3, 1'b0);
        exp_dr++;
        repeat (2) tick();

        // Write in the capture cycle: old word sent now, new word next frame
        start(1'b0, 1'b1, 0, 16'h1234);
        bits(NBITS, 1, 2, 1'b0);
        exp_dr++;
        tick();
        start(1'b1, 1'b0, 0, '0);
        bits(NBITS, 1, 2, 1'b0);
        exp_dr++;
        repeat (2) tick();

        // Reset mid-frame aborts without downrupt
        start(1'b1, 1'b0, 0, '0);
        bits(10, 1, 2, 1'b0);
        abort_pending = 1'b1;
        rst = 1'b1;
        m_reset();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_dk_data", 64'(bus.dk_data), 64'd0);
        check("abort_bit_ctr", 64'(bus.bit_ctr), 64'd0);
        d0 = mon_dr;
        repeat (40) tick();
        check("abort_no_downrupt", 64'(mon_dr), 64'(d0));

        // Randomized frames with mid-frame writes, DONE restarts and idle bit-syncs
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 1) == 1) do_write(0, WORD_W'($urandom));
            if ($urandom_range(0, 1) == 1) do_write(1, WORD_W'($urandom));
            start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, NWORDS-1), WORD_W'($urandom));
            bits(NBITS, 1, 4, 1'b1);
            exp_dr++;
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    bus.dk_bsnc = 1'($urandom_range(0, 1));
                    tick();
                    bus.dk_bsnc = 1'b0;
                end
            end
        end
        start(1'b1, 1'b0, 0, '0);
        bits(NBITS, 1, 2, 1'b0);
        exp_dr++;
        repeat (5) tick();
        @(negedge clk);
        check("scoreboard_empty", 64'(q.size()), 64'd0);
        check("downrupt_count", 64'(mon_dr), 64'(exp_dr));
        check("final_overrun", 64'(bus.overrun), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dnlink_serializer.md
DNLINK_SERIALIZER -- requirements
Module: dnlink_serializer

Interface
REQ-001 Parameter WORD_W, default 16, bits per telemetry word, range 2..32.
REQ-002 Parameter NWORDS, default 2, words per frame, range 1..16.
REQ-003 Derived: IDXW = max(1, clog2(NWORDS)); NBITS = 1 + NWORDS*WORD_W; CTRW = clog2(NBITS+1).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 CLOCK  in  1  system clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 wr_en  in  1  write strobe into the holding buffer.
REQ-008 wr_idx  in  IDXW  holding-buffer word index.
REQ-009 wr_data  in  WORD_W  word to store.
REQ-010 order_in  in  1  word-order bit, sampled at frame start.
REQ-011 dk_strt  in  1  frame-start strobe, one cycle.
REQ-012 dk_bsnc  in  1  bit-sync strobe, one cycle per bit advance.
REQ-013 clr_ovr  in  1  clears the overrun flag.
REQ-014 dk_data  out  1  serial data, registered.
REQ-015 busy  out  1  frame in progress.
REQ-016 bit_ctr  out  CTRW  index of the bit currently on dk_data; 0 when idle.
REQ-017 downrupt  out  1  one-cycle end-of-frame pulse.
REQ-018 stale  out  1  the current/last frame contained at least one word not rewritten since the previous capture.
REQ-019 overrun  out  1  sticky; a dk_strt arrived while busy.

Function
REQ-020 The block SHALL hold an NWORDS x WORD_W holding buffer, one fresh flag per word, and a shadow shift register of NBITS bits.
REQ-021 wr_en with wr_idx < NWORDS SHALL write the word and set its fresh flag; wr_idx >= NWORDS SHALL be ignored.
REQ-022 States: IDLE, SHIFT, DONE.
REQ-023 IDLE + dk_strt: capture {order_in, word0..wordN-1} into the shadow register (word0 first, each MSB first), set stale = NOT(all fresh), clear all fresh flags, and enter SHIFT.
REQ-024 Latency: dk_strt at cycle N -> busy=1, bit_ctr=0, dk_data=order bit at N+1.
REQ-025 SHIFT + dk_bsnc at cycle M, with bit_ctr < NBITS-1: bit_ctr increments and dk_data shows the next bit at M+1.
REQ-026 SHIFT + dk_bsnc with bit_ctr = NBITS-1: enter DONE at M+1, with busy=0, downrupt=1, dk_data=0, bit_ctr=0.
REQ-027 DONE SHALL last exactly one cycle, then return to IDLE with downrupt=0; in DONE, dk_strt SHALL be treated as in IDLE.
REQ-028 dk_strt in SHIFT SHALL be ignored for data and SHALL set overrun; clr_ovr SHALL clear it, and a set in the same cycle as clr_ovr wins.
REQ-029 dk_bsnc in IDLE/DONE SHALL be ignored; dk_bsnc in the same cycle as a starting dk_strt SHALL be ignored.
REQ-030 wr_en in the same cycle as the capture: the capture SHALL take the old value, the new word SHALL land in the holding buffer, and its fresh flag SHALL end at 1.
REQ-031 Writes during SHIFT SHALL not disturb the frame being sent.
REQ-032 stale SHALL hold from capture until the next capture.

Reset
REQ-033 rst SHALL force IDLE and clear busy, dk_data, bit_ctr, downrupt, stale, overrun, all fresh flags, the holding buffer and the shadow register to 0.
REQ-034 rst SHALL take precedence over all inputs, including mid-frame; an aborted frame SHALL produce no downrupt.

Verification (defaults: WORD_W=16, NWORDS=2, NBITS=33)
REQ-035 Release rst, no stimulus for 10 cycles -> all outputs 0.
REQ-036 Write idx0=16'hA5C3 and idx1=16'h0F0F; order_in=1; dk_strt; then 33 dk_bsnc spaced 3 cycles apart -> dk_data sequence 1, A5C3 MSB-first, 0F0F MSB-first; stale=0; a single downrupt one cycle after the 33rd dk_bsnc; busy=0 at that cycle.
REQ-037 Second dk_strt with no intervening writes -> identical 33-bit sequence and stale=1.
REQ-038 dk_strt after the 5th dk_bsnc -> the frame is unaffected and overrun=1; clr_ovr -> overrun=0 on the next cycle.
REQ-039 rst after the 10th dk_bsnc -> next cycle busy=0, dk_data=0, bit_ctr=0; no downrupt within the following 40 cycles.
REQ-040 wr_en idx0=16'h1234 in the same cycle as dk_strt -> the current frame sends the old word0; the next frame sends 1234 in the word0 slot and reports stale=1 (word1 not rewritten).
